// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue: memory handshake codes,
// fetch FSM encoding and bus widths.
package if_fetch_queue_pkg;

    localparam int unsigned InstAddrBusW = 32;
    localparam int unsigned InstBusW     = 32;

    // mem_status codes returned by the memory controller
    localparam logic [1:0] MemInit = 2'b00;
    localparam logic [1:0] MemBusy = 2'b01;
    localparam logic [1:0] MemDone = 2'b10;

    typedef enum logic [1:0] {
        StFetch   = 2'b00,
        StMemWait = 2'b01,
        StDrop    = 2'b10
    } fetch_state_e;

    // Queue entry: {pc, inst, pred_taken, pred_target}
    function automatic int unsigned fq_entry_w(input int unsigned xlen);
        return 3 * xlen + 1;
    endfunction

endpackage

// File: rtl/fq_ring.sv
// Generic DEPTH x W circular buffer with push, pop, flush and occupancy count.
// A push into a full ring is accepted only when a pop frees a slot in the same cycle.
module fq_ring #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 97,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [PTR_W:0]   count,
    output logic             full
);

    localparam int unsigned CW = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap for free
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Run-ahead instruction fetch stage: fills a DEPTH-entry queue from the icache on a hit,
// otherwise from memory, steering the fetch PC with the BTB. EX redirects flush everything.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN     = InstAddrBusW,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PTR_W    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] ic_addr,
    input  logic            ic_hit,
    input  logic [XLEN-1:0] ic_val,
    output logic [XLEN-1:0] btb_addr,
    input  logic            btb_hit,
    input  logic [XLEN-1:0] btb_pred,
    output logic            mem_rw,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic [1:0]      mem_status,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [XLEN-1:0] deq_pc,
    output logic [XLEN-1:0] deq_inst,
    output logic            deq_pred_taken,
    output logic [XLEN-1:0] deq_pred_target,
    output logic [PTR_W:0]  count
);

    localparam int unsigned EntryW = fq_entry_w(XLEN);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic            mem_done;
    logic            pop_fire;
    logic            room;
    logic            push;
    logic            issue;
    logic            full;
    logic [XLEN-1:0] enq_pc;
    logic [XLEN-1:0] enq_inst;
    logic [XLEN-1:0] next_pc;
    logic [EntryW-1:0] enq_entry;
    logic [EntryW-1:0] head_entry;

    assign mem_done  = (mem_status == MemDone);
    assign deq_valid = (count != '0);
    // A redirect voids any same-cycle pop
    assign pop_fire  = rdy && deq_ready && deq_valid && !redirect_e;
    assign room      = !full || pop_fire;

    // In MEM_WAIT fetch_pc equals req_pc, so the BTB lookup on fetch_pc covers both sources
    assign enq_pc    = (state_q == StMemWait) ? req_pc_q : fetch_pc_q;
    assign enq_inst  = (state_q == StMemWait) ? mem_data : ic_val;
    assign next_pc   = btb_hit ? btb_pred : enq_pc + XLEN'(4);
    assign enq_entry = {enq_pc, enq_inst, btb_hit, next_pc};

    assign ic_addr  = fetch_pc_q;
    assign btb_addr = fetch_pc_q;
    assign mem_addr = req_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_e) begin
            case (state_q)
                StMemWait: state_d = mem_done ? StFetch : StDrop;
                StDrop:    if (rdy && mem_done) state_d = StFetch;
                default:   state_d = state_q;
            endcase
        end else if (rdy) begin
            case (state_q)
                StFetch:           if (room && !ic_hit) state_d = StMemWait;
                StMemWait, StDrop: if (mem_done) state_d = StFetch;
                default:           state_d = StFetch;
            endcase
        end
    end

    always_comb begin
        push  = 1'b0;
        issue = 1'b0;
        if (!redirect_e && rdy) begin
            case (state_q)
                StFetch: begin
                    push  = room && ic_hit;
                    issue = room && !ic_hit;
                end
                StMemWait: push = mem_done;
                default: begin
                    push  = 1'b0;
                    issue = 1'b0;
                end
            endcase
        end
        // Request drops combinationally in the DONE cycle
        mem_rw = (state_q != StFetch) && !mem_done;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_e) begin
            fetch_pc_d = redirect_pc;
        end else if (push) begin
            fetch_pc_d = next_pc;
        end
        if (issue) begin
            req_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fq_ring #(
        .DEPTH (DEPTH),
        .W     (EntryW),
        .PTR_W (PTR_W)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_e),
        .push  (push),
        .pop   (pop_fire),
        .wdata (enq_entry),
        .rdata (head_entry),
        .count (count),
        .full  (full)
    );

    assign {deq_pc, deq_inst, deq_pred_taken, deq_pred_target} = head_entry;

endmodule
